// File: rtl/s_block_writer_if.sv
// Handshake and memory bus between the block controller, the S DPRAM and the SRAM image writer.
// The slave modport is the writer's view; the master modport is the controller/memory side.
interface s_block_writer_if;
    logic        WB_start;
    logic        WB_done;
    logic [4:0]  block_row;
    logic [5:0]  block_col;
    logic [6:0]  S_read_address;
    logic [31:0] S_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output WB_start, block_row, block_col, S_read_data,
        input  WB_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        input  WB_start, block_row, block_col, S_read_data,
        output WB_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/s_block_writer.sv
// Reads an 8x8 block of S values, descales/clips each to a pixel and writes packed pixel pairs to SRAM.
// Start to done pulse is 67 cycles; no backpressure, one SRAM write every other cycle from cycle 4.
module s_block_writer #(
    parameter logic [6:0]  S_BASE      = 7'd0,
    parameter logic [17:0] BASE_ADDR   = 18'd0,
    parameter int          WIDTH_WORDS = 160,
    parameter int          SHIFT       = 16
) (
    input  logic             CLOCK_50_I,
    input  logic             Resetn,
    s_block_writer_if.slave  bus
);

    localparam logic [17:0] L_WIDTH = 18'(WIDTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LEAD_OUT,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [4:0]   r_blk_row;
    logic [5:0]   r_blk_col;
    logic [5:0]   r_rd_cnt;
    logic [6:0]   r_rd_addr;
    logic         r_data_vld;
    logic [5:0]   r_pix_cnt;
    logic [7:0]   r_even;
    logic [17:0]  r_wr_addr;
    logic [15:0]  r_wr_data;
    logic         r_we_n;
    logic         r_done;

    logic         w_start;
    logic signed [31:0] w_v;
    logic [7:0]   w_pix;
    logic [17:0]  w_row;
    logic [17:0]  w_wr_addr;

    assign w_start = (r_state == S_IDLE) && bus.WB_start;

    always_ff @(posedge CLOCK_50_I) begin
        if (Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.WB_start) w_next = S_RUN;
            S_RUN:      if (r_rd_cnt == 6'd63) w_next = S_LEAD_OUT;
            S_LEAD_OUT: w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign w_v = $signed(bus.S_read_data) >>> SHIFT;

    always_comb begin
        w_pix = w_v[7:0];
        if (w_v < 32'sd0) begin
            w_pix = 8'd0;
        end else if (w_v > 32'sd255) begin
            w_pix = 8'hFF;
        end
    end

    // pixel counter bits [5:3] are the block row, [2:1] the word within that row
    assign w_row     = {10'd0, r_blk_row, 3'b000} + {15'd0, r_pix_cnt[5:3]};
    assign w_wr_addr = BASE_ADDR + w_row * L_WIDTH
                     + {10'd0, r_blk_col, 2'b00} + {16'd0, r_pix_cnt[2:1]};

    always_ff @(posedge CLOCK_50_I) begin
        if (Resetn) begin
            r_blk_row  <= '0;
            r_blk_col  <= '0;
            r_rd_cnt   <= '0;
            r_rd_addr  <= S_BASE;
            r_data_vld <= 1'b0;
            r_pix_cnt  <= '0;
            r_even     <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_we_n     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done     <= (r_state == S_DONE);
            r_data_vld <= (r_state == S_RUN);
            r_we_n     <= 1'b1;

            if (w_start) begin
                r_blk_row <= bus.block_row;
                r_blk_col <= bus.block_col;
                r_rd_cnt  <= '0;
                r_rd_addr <= S_BASE;
                r_pix_cnt <= '0;
            end else if (r_state == S_RUN && r_rd_cnt != 6'd63) begin
                r_rd_cnt  <= r_rd_cnt + 6'd1;
                r_rd_addr <= S_BASE + {1'b0, r_rd_cnt} + 7'd1;
            end

            // DPRAM data lags its address by one cycle, tracked by r_data_vld
            if (r_data_vld) begin
                r_pix_cnt <= r_pix_cnt + 6'd1;
                if (!r_pix_cnt[0]) begin
                    r_even <= w_pix;
                end else begin
                    r_wr_addr <= w_wr_addr;
                    r_wr_data <= {r_even, w_pix};
                    r_we_n    <= 1'b0;
                end
            end
        end
    end

    assign bus.WB_done         = r_done;
    assign bus.S_read_address  = r_rd_addr;
    assign bus.SRAM_address    = r_wr_addr;
    assign bus.SRAM_write_data = r_wr_data;
    assign bus.SRAM_we_n       = r_we_n;

endmodule

// File: tb/tb_s_block_writer.sv
// Bench for s_block_writer: DPRAM model, write scoreboard and per-scenario checks.
module tb_s_block_writer;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        resetn;
    logic [31:0] mem [0:127];
    logic [6:0]  obs_raddr [0:255];
    wr_t         exp_q [$];
    wr_t         obs_q [$];
    int          done_q [$];
    int          n_checks;
    int          n_pass;

    s_block_writer_if bus ();

    s_block_writer dut (
        .CLOCK_50_I (clk),
        .Resetn     (resetn),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.S_read_data <= mem[bus.S_read_address];

    function automatic logic [7:0] model_pix(input logic [31:0] s);
        int v;
        v = $signed(s) >>> 16;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    task automatic push_block(input int row, input int col, input int off, input int nwords);
        wr_t e;
        for (int w = 0; w < nwords; w++) begin
            e.cyc  = off + 2 * w + 4;
            e.addr = 18'((8 * row + w / 4) * 160 + 4 * col + (w % 4));
            e.data = {model_pix(mem[2 * w]), model_pix(mem[2 * w + 1])};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_block(input int row, input int col, input int ncyc, input int hold_until,
                             input int restart_at, input int new_col, input int rst_at);
        wr_t o;
        obs_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.block_row = 5'(row);
        bus.block_col = 6'(col);
        bus.WB_start  = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (bus.SRAM_we_n === 1'b0) begin
                o.cyc  = k;
                o.addr = bus.SRAM_address;
                o.data = bus.SRAM_write_data;
                obs_q.push_back(o);
            end
            if (bus.WB_done === 1'b1) done_q.push_back(k);
            if (k < 256) obs_raddr[k] = bus.S_read_address;
            if (k == hold_until) bus.WB_start = 1'b0;
            if (k == restart_at) begin
                bus.WB_start  = 1'b1;
                bus.block_col = 6'(new_col);
            end
            if (k == restart_at + 1) bus.WB_start = 1'b0;
            if (k == rst_at) resetn = 1'b1;
            if (k == rst_at + 1) resetn = 1'b0;
        end
    endtask

    task automatic test_reset;
        resetn       = 1'b1;
        bus.WB_start = 1'b0;
        bus.block_row = '0;
        bus.block_col = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.SRAM_we_n !== 1'b1) $display("FAIL reset we_n: got %b want 1", bus.SRAM_we_n); else n_pass++;
        n_checks++; if (bus.WB_done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.WB_done); else n_pass++;
        n_checks++; if (bus.SRAM_address !== 18'd0) $display("FAIL reset addr: got %0d want 0", bus.SRAM_address); else n_pass++;
        n_checks++; if (bus.SRAM_write_data !== 16'd0) $display("FAIL reset wdata: got %h want 0", bus.SRAM_write_data); else n_pass++;
        n_checks++; if (bus.S_read_address !== 7'd0) $display("FAIL reset raddr: got %0d want 0", bus.S_read_address); else n_pass++;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_uniform;
        wr_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0080_0000;
        exp_q.delete();
        push_block(0, 0, 0, 32);
        run_block(0, 0, 75, 1, -1, 0, -1);
        for (int k = 1; k <= 64; k++) begin
            n_checks++;
            if (obs_raddr[k] !== 7'(k - 1)) $display("FAIL uniform raddr c%0d: got %0d want %0d", k, obs_raddr[k], k - 1);
            else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL uniform missing write: got none want a%0d c%0d", e.addr, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL uniform write: got c%0d a%0d d%h want c%0d a%0d d%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL uniform extra writes: got %0d want 0", obs_q.size()); else n_pass++;
        n_checks++;
        if (done_q.size() != 1 || done_q[0] != 67) $display("FAIL uniform done: got %0d pulses want 1 at c67", done_q.size());
        else n_pass++;
    endtask

    task automatic test_clip;
        wr_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'hFFFF_0000;
        mem[1] = 32'h0100_0000;
        mem[2] = 32'h00FF_FFFF;
        mem[3] = 32'h0000_FFFF;
        exp_q.delete();
        push_block(3, 5, 0, 32);
        run_block(3, 5, 75, 1, -1, 0, -1);
        n_checks++;
        if (obs_q.size() < 2 || obs_q[0].data !== 16'h00FF) $display("FAIL clip word0: got %0d writes want data 00ff", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q.size() < 2 || obs_q[1].data !== 16'hFF00) $display("FAIL clip word1: got %0d writes want data ff00", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL clip missing write: got none want a%0d c%0d", e.addr, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL clip write: got c%0d a%0d d%h want c%0d a%0d d%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL clip extra writes: got %0d want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_corner;
        wr_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        exp_q.delete();
        push_block(29, 39, 0, 32);
        run_block(29, 39, 75, 1, -1, 0, -1);
        n_checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1].addr !== 18'd38399) $display("FAIL corner last addr: got %0d writes want last a38399", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL corner missing write: got none want a%0d c%0d", e.addr, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL corner write: got c%0d a%0d d%h want c%0d a%0d d%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL corner extra writes: got %0d want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_hold_start;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        run_block(2, 7, 100, 67, -1, 0, -1);
        n_checks++; if (obs_q.size() != 32) $display("FAIL hold writes: got %0d want 32", obs_q.size()); else n_pass++;
        n_checks++;
        if (done_q.size() != 1 || done_q[0] != 67) $display("FAIL hold done: got %0d pulses want 1 at c67", done_q.size());
        else n_pass++;
        run_block(2, 7, 75, 1, -1, 0, -1);
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0].cyc != 4) $display("FAIL hold restart first write: got %0d writes want first at c4", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        wr_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        exp_q.delete();
        push_block(1, 2, 0, 14);
        run_block(1, 2, 90, 1, -1, 0, 30);
        n_checks++; if (obs_raddr[31] !== 7'd0) $display("FAIL midreset raddr: got %0d want 0", obs_raddr[31]); else n_pass++;
        n_checks++; if (done_q.size() != 0) $display("FAIL midreset done: got %0d pulses want 0", done_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL midreset missing write: got none want a%0d c%0d", e.addr, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL midreset write: got c%0d a%0d d%h want c%0d a%0d d%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL midreset extra writes: got %0d want 0", obs_q.size()); else n_pass++;
        run_block(1, 2, 75, 1, -1, 0, -1);
        n_checks++; if (obs_q.size() != 32) $display("FAIL midreset fresh writes: got %0d want 32", obs_q.size()); else n_pass++;
        n_checks++;
        if (done_q.size() != 1 || done_q[0] != 67) $display("FAIL midreset fresh done: got %0d pulses want 1 at c67", done_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        wr_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        exp_q.delete();
        push_block(0, 0, 0, 32);
        push_block(0, 1, 67, 32);
        run_block(0, 0, 145, 1, 67, 1, -1);
        n_checks++;
        if (obs_q.size() < 33 || obs_q[32].addr !== 18'd4) $display("FAIL b2b second first addr: got %0d writes want a4", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL b2b missing write: got none want a%0d c%0d", e.addr, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL b2b write: got c%0d a%0d d%h want c%0d a%0d d%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL b2b extra writes: got %0d want 0", obs_q.size()); else n_pass++;
        n_checks++;
        if (done_q.size() != 2 || done_q[0] != 67 || done_q[1] != 134) $display("FAIL b2b done: got %0d pulses want c67 and c134", done_q.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_uniform();
        test_clip();
        test_corner();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
